multiplicador_booth_param: RTL and testbench

//   Parametrised radix-2 Booth sequential multiplier: WIDTH-bit operands, 2*WIDTH-bit product.
//   Run-time selectable signed/unsigned mode; start/fin handshake with busy flag.

---
 rtl/multiplicador_booth_param_if.sv | 23 ++
 rtl/multiplicador_booth_param.sv | 186 ++++++++++++++++++
 tb/tb_multiplicador_booth_param.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/multiplicador_booth_param_if.sv
// Handshake/operand bundle for the parametrised Booth multiplier.
// The master drives the request and operands; the slave returns the product and status.
interface multiplicador_booth_param_if #(
  parameter int WIDTH = 3
);
  logic                 start;
  logic                 signo;
  logic [WIDTH-1:0]     Mcando;
  logic [WIDTH-1:0]     Mcador;
  logic [2*WIDTH-1:0]   producto;
  logic                 fin;
  logic                 ocupado;

  modport master (
    output start, signo, Mcando, Mcador,
    input  producto, fin, ocupado
  );

  modport slave (
    input  start, signo, Mcando, Mcador,
    output producto, fin, ocupado
  );
endinterface

// File: rtl/multiplicador_booth_param.sv
// Radix-2 Booth sequential multiplier, WIDTH-bit operands, 2*WIDTH-bit product.
// Signed/unsigned mode per operation; start/fin handshake with a busy flag.
module multiplicador_booth_param #(
  parameter int WIDTH = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  multiplicador_booth_param_if.slave     bus
);

  // One extra operand bit makes unsigned operands look like positive signed ones.
  localparam int N     = WIDTH + 1;
  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CARGA = 2'd1,
    OPERA = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [WIDTH-1:0]     r_mcando;
  logic [WIDTH-1:0]     r_mcador;
  logic                 r_signo;
  logic [N:0]           r_a;
  logic [N-1:0]         r_q;
  logic                 r_q1;
  logic [N-1:0]         r_m;
  logic [CNT_W-1:0]     r_cnt;
  logic [2*WIDTH-1:0]   r_producto;
  logic                 r_fin;
  logic                 r_ocupado;

  logic [WIDTH-1:0]     w_mcando_nxt;
  logic [WIDTH-1:0]     w_mcador_nxt;
  logic                 w_signo_nxt;
  logic [N:0]           w_a_nxt;
  logic [N-1:0]         w_q_nxt;
  logic                 w_q1_nxt;
  logic [N-1:0]         w_m_nxt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [2*WIDTH-1:0]   w_producto_nxt;
  logic                 w_fin_nxt;
  logic                 w_ocupado_nxt;
  logic [N:0]           w_m_ext;
  logic [N:0]           w_sum;

  function automatic logic [N-1:0] f_ext(input logic [WIDTH-1:0] x, input logic s);
    return {s & x[WIDTH-1], x};
  endfunction

  assign w_m_ext = {r_m[N-1], r_m};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt = CARGA;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      CARGA: begin
        w_state_nxt = OPERA;
      end
      OPERA: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = FIN;
        end else begin
          w_state_nxt = OPERA;
        end
      end
      FIN: begin
        if (bus.start) begin
          w_state_nxt = CARGA;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    w_mcando_nxt   = r_mcando;
    w_mcador_nxt   = r_mcador;
    w_signo_nxt    = r_signo;
    w_a_nxt        = r_a;
    w_q_nxt        = r_q;
    w_q1_nxt       = r_q1;
    w_m_nxt        = r_m;
    w_cnt_nxt      = r_cnt;
    w_producto_nxt = r_producto;
    w_sum          = r_a;
    w_fin_nxt      = (w_state_nxt == FIN);
    w_ocupado_nxt  = (w_state_nxt == CARGA) || (w_state_nxt == OPERA);

    case (r_state)
      IDLE, FIN: begin
        if (bus.start) begin
          w_mcando_nxt = bus.Mcando;
          w_mcador_nxt = bus.Mcador;
          w_signo_nxt  = bus.signo;
        end else begin
          w_mcando_nxt = r_mcando;
          w_mcador_nxt = r_mcador;
          w_signo_nxt  = r_signo;
        end
      end
      CARGA: begin
        w_a_nxt   = {(N+1){1'b0}};
        w_q_nxt   = f_ext(r_mcador, r_signo);
        w_q1_nxt  = 1'b0;
        w_m_nxt   = f_ext(r_mcando, r_signo);
        w_cnt_nxt = CNT_W'(N);
      end
      OPERA: begin
        case ({r_q[0], r_q1})
          2'b01:   w_sum = r_a + w_m_ext;
          2'b10:   w_sum = r_a - w_m_ext;
          default: w_sum = r_a;
        endcase
        // Arithmetic shift of {A,Q,Q-1}; the guard bit of A keeps the sign exact.
        w_a_nxt   = {w_sum[N], w_sum[N:1]};
        w_q_nxt   = {w_sum[0], r_q[N-1:1]};
        w_q1_nxt  = r_q[0];
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_producto_nxt = {w_a_nxt[WIDTH-2:0], w_q_nxt};
        end else begin
          w_producto_nxt = r_producto;
        end
      end
      default: begin
        w_cnt_nxt = r_cnt;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcando   <= {WIDTH{1'b0}};
      r_mcador   <= {WIDTH{1'b0}};
      r_signo    <= 1'b0;
      r_a        <= {(N+1){1'b0}};
      r_q        <= {N{1'b0}};
      r_q1       <= 1'b0;
      r_m        <= {N{1'b0}};
      r_cnt      <= {CNT_W{1'b0}};
      r_producto <= {(2*WIDTH){1'b0}};
      r_fin      <= 1'b0;
      r_ocupado  <= 1'b0;
    end else begin
      r_mcando   <= w_mcando_nxt;
      r_mcador   <= w_mcador_nxt;
      r_signo    <= w_signo_nxt;
      r_a        <= w_a_nxt;
      r_q        <= w_q_nxt;
      r_q1       <= w_q1_nxt;
      r_m        <= w_m_nxt;
      r_cnt      <= w_cnt_nxt;
      r_producto <= w_producto_nxt;
      r_fin      <= w_fin_nxt;
      r_ocupado  <= w_ocupado_nxt;
    end
  end

  assign bus.producto = r_producto;
  assign bus.fin      = r_fin;
  assign bus.ocupado  = r_ocupado;

endmodule

// File: tb/tb_multiplicador_booth_param.sv
// Self-checking bench: vector table, exhaustive WIDTH=3 sweep, scoreboard of expected
// products with latency/pulse/busy checks, plus back-to-back, mid-op start and reset-abort cases.
module tb_multiplicador_booth_param;

  localparam int W = 3;
  localparam int N = W + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multiplicador_booth_param_if #(.WIDTH(W)) bus3 ();
  multiplicador_booth_param_if #(.WIDTH(4)) bus4 ();

  multiplicador_booth_param #(.WIDTH(W)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));
  multiplicador_booth_param #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  typedef struct {
    logic [5:0] exp;
    int         acc;
  } sb_t;

  typedef struct {
    logic [2:0] a;
    logic [2:0] b;
    logic       s;
    logic [5:0] exp;
  } vec_t;

  sb_t  sbq[$];
  sb_t  mon_e;
  vec_t tbl[8];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   occ    = 0;
  logic prev_fin = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] ref_mul(input logic [2:0] a, input logic [2:0] b, input logic s);
    int ai;
    int bi;
    int p;
    ai = s ? int'($signed(a)) : int'(a);
    bi = s ? int'($signed(b)) : int'(b);
    p  = ai * bi;
    return p[5:0];
  endfunction

  // Scoreboard monitor: every fin pops one expected product and checks timing.
  always @(negedge clk) begin
    if (!rst_n) begin
      occ      = 0;
      prev_fin = 1'b0;
    end else begin
      if (bus3.fin) begin
        chk("fin_single_cycle", {31'd0, prev_fin}, 32'd0);
        chk("ocupado_len", occ, N + 1);
        occ = 0;
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_fin: got fin with producto %0h, expected no fin (t=%0t)",
                   bus3.producto, $time);
        end else begin
          mon_e = sbq.pop_front();
          chk("producto", {26'd0, bus3.producto}, {26'd0, mon_e.exp});
          chk("latency", cyc - mon_e.acc, N + 1);
        end
      end else if (bus3.ocupado) begin
        occ++;
      end
      prev_fin = bus3.fin;
    end
  end

  task automatic wait_drain();
    for (int i = 0; i < 20 && sbq.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    chk("drain_timeout", sbq.size(), 0);
    sbq.delete();
  endtask

  task automatic run_op(input logic [2:0] a, input logic [2:0] b, input logic s, input logic [5:0] exp);
    bus3.Mcando = a;
    bus3.Mcador = b;
    bus3.signo  = s;
    bus3.start  = 1'b1;
    @(posedge clk);
    #1;
    sbq.push_back('{exp, cyc});
    bus3.start  = 1'b0;
    bus3.Mcando = ~a;
    bus3.Mcador = ~b;
    bus3.signo  = ~s;
    wait_drain();
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic s, input logic [7:0] exp);
    bus4.Mcando = a;
    bus4.Mcador = b;
    bus4.signo  = s;
    bus4.start  = 1'b1;
    @(posedge clk);
    #1;
    bus4.start = 1'b0;
    for (int i = 0; i < 20 && !bus4.fin; i++) begin
      @(negedge clk);
    end
    chk("w4_fin_seen", {31'd0, bus4.fin}, 32'd1);
    chk("w4_producto", {24'd0, bus4.producto}, {24'd0, exp});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] pa[4];
    logic [2:0] pb[4];
    logic       ps[4];

    tbl[0] = '{3'd3, 3'b110, 1'b1, 6'b111010};
    tbl[1] = '{3'b100, 3'b100, 1'b1, 6'b010000};
    tbl[2] = '{3'b100, 3'd3, 1'b1, 6'b110100};
    tbl[3] = '{3'd7, 3'd7, 1'b0, 6'd49};
    tbl[4] = '{3'd4, 3'd3, 1'b0, 6'd12};
    tbl[5] = '{3'd3, 3'd3, 1'b1, 6'd9};
    tbl[6] = '{3'b111, 3'b111, 1'b1, 6'd1};
    tbl[7] = '{3'd0, 3'd5, 1'b0, 6'd0};

    pa = '{3'd3, 3'd5, 3'd2, 3'd7};
    pb = '{3'd6, 3'd1, 3'd4, 3'd7};
    ps = '{1'b1, 1'b0, 1'b1, 1'b0};

    bus3.start = 1'b0; bus3.signo = 1'b0; bus3.Mcando = 3'd0; bus3.Mcador = 3'd0;
    bus4.start = 1'b0; bus4.signo = 1'b0; bus4.Mcando = 4'd0; bus4.Mcador = 4'd0;

    #12;
    chk("reset_producto", {26'd0, bus3.producto}, 32'd0);
    chk("reset_fin", {31'd0, bus3.fin}, 32'd0);
    chk("reset_ocupado", {31'd0, bus3.ocupado}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].exp);
    end

    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 8; a++) begin
        for (int b = 0; b < 8; b++) begin
          run_op(3'(a), 3'(b), 1'(s), ref_mul(3'(a), 3'(b), 1'(s)));
        end
      end
    end

    op4(4'd15, 4'd15, 1'b0, 8'd225);
    op4(4'd15, 4'd15, 1'b1, 8'd1);

    // start held high: new operands each op, accepts every N+2 cycles
    repeat (2) @(posedge clk);
    #1;
    bus3.Mcando = pa[0]; bus3.Mcador = pb[0]; bus3.signo = ps[0];
    bus3.start  = 1'b1;
    @(posedge clk);
    #1;
    for (int j = 0; j < 4; j++) begin
      sbq.push_back('{ref_mul(pa[j], pb[j], ps[j]), cyc});
      if (j < 3) begin
        bus3.Mcando = pa[j+1]; bus3.Mcador = pb[j+1]; bus3.signo = ps[j+1];
        repeat (N + 2) @(posedge clk);
        #1;
      end else begin
        bus3.start = 1'b0;
      end
    end
    wait_drain();

    // start pulse in the middle of OPERA must be ignored
    bus3.Mcando = 3'd2; bus3.Mcador = 3'd3; bus3.signo = 1'b1;
    bus3.start  = 1'b1;
    @(posedge clk);
    #1;
    sbq.push_back('{6'd6, cyc});
    bus3.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus3.Mcando = 3'd7; bus3.Mcador = 3'd7; bus3.signo = 1'b0;
    bus3.start  = 1'b1;
    @(posedge clk);
    #1;
    bus3.start = 1'b0;
    wait_drain();
    repeat (8) @(posedge clk);
    #1;
    chk("idle_after_pulse", {31'd0, bus3.ocupado}, 32'd0);

    // reset during the second Booth step aborts without fin
    run_op(3'd3, 3'd3, 1'b1, 6'd9);
    bus3.Mcando = 3'd3; bus3.Mcador = 3'd2; bus3.signo = 1'b1;
    bus3.start  = 1'b1;
    @(posedge clk);
    #1;
    bus3.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_producto", {26'd0, bus3.producto}, 32'd0);
    chk("abort_fin", {31'd0, bus3.fin}, 32'd0);
    chk("abort_ocupado", {31'd0, bus3.ocupado}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_op(3'd2, 3'd5, 1'b0, 6'd10);
    repeat (4) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
